// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo -- single-clock first-word-fall-through FIFO.
//
// The head word is always visible on dout while the FIFO holds data, so a
// consumer can look at it and pop it in the same cycle. The storage is a plain
// register array. It is not reset, so it may map onto RAM-style resources.
//
// Parameters
//   DATA_WIDTH    width of each stored word (>= 1)
//   MEMORY_DEPTH  number of entries (power of two, >= 2)
//
// Ports
//   clk    in   sole clock, rising edge
//   rst    in   asynchronous reset, active low
//   empty  out  count == 0
//   full   out  count == MEMORY_DEPTH
//   count  out  number of stored words, 0..MEMORY_DEPTH
//   rd     in   pop request
//   dout   out  head word, zero while empty
//   wr     in   push request
//   din    in   word to push
// -----------------------------------------------------------------------------
module fifo #(
    parameter  int DATA_WIDTH   = 8,
    parameter  int MEMORY_DEPTH = 16,
    localparam int AW           = $clog2(MEMORY_DEPTH),
    localparam int CW           = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  empty,
    output logic                  full,
    output logic [CW-1:0]         count,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din
);

    logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];
    logic [AW-1:0]         wp_q, wp_d;
    logic [AW-1:0]         rp_q, rp_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  rd_ok;
    logic                  wr_ok;

    // Flags come straight from the registered count. This gives them no
    // extra latency relative to count.
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(MEMORY_DEPTH));
    assign count = count_q;

    // A pop is only honoured when there is something to pop. A push is
    // honoured when there is room. A push is also honoured when full if the
    // same cycle pops the head, because that frees the slot at wp. When full,
    // wp == rp, so the pop reads the old head before the edge overwrites it.
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);

    // First-word-fall-through: no read latency, forced to zero while empty.
    assign dout = empty ? '0 : mem_q[rp_q];

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        // AW-bit pointers wrap modulo MEMORY_DEPTH on their own, because the
        // depth is a power of two.
        if (wr_ok) wp_d = wp_q + AW'(1);
        if (rd_ok) rp_d = rp_q + AW'(1);
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset. Stale words are never visible, because dout is
    // masked while empty and rp only reaches entries that have been written.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wp_q] <= din;
    end

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

    localparam int DW    = 7;
    localparam int DEPTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          rd;
    logic [DW-1:0] dout;
    logic          wr;
    logic [DW-1:0] din;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: an ordered list of the stored words.
    logic [DW-1:0] mq[$];

    fifo #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .empty (empty),
        .full  (full),
        .count (count),
        .rd    (rd),
        .dout  (dout),
        .wr    (wr),
        .din   (din)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] model_head();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    // Drive one cycle of requests and advance the model by the FIFO rules.
    // Outputs can be sampled when this returns, which is 1 time unit after the edge.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
        bit rok, wok;
        wr = w; rd = r; din = d;
        @(posedge clk);
        rok = r && (mq.size() > 0);
        wok = w && ((mq.size() < DEPTH) || rok);
        if (rok) void'(mq.pop_front());
        if (wok) mq.push_back(d);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b exp 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b exp 0", full); end
        vectors++; if (count !== CW'(0)) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
        vectors++; if (dout !== DW'(0)) begin miscompares++; $display("FAIL reset_dout got %h exp 0", dout); end
        rst = 1'b1;
        mq.delete();
        @(posedge clk); #1;
        vectors++; if (empty !== 1'b1 || count !== CW'(0)) begin
            miscompares++; $display("FAIL post_reset_idle empty=%b count=%0d exp 1/0", empty, count);
        end
    endtask

    task automatic test_basic();
        cycle(1, 0, 7'h41); cycle(1, 0, 7'h42); cycle(1, 0, 7'h43);
        vectors++; if (count !== CW'(3)) begin miscompares++; $display("FAIL basic_count got %0d exp 3", count); end
        vectors++; if (dout !== 7'h41) begin miscompares++; $display("FAIL basic_head got %h exp 41", dout); end
        cycle(0, 1, '0);
        vectors++; if (dout !== 7'h42) begin miscompares++; $display("FAIL basic_pop1 got %h exp 42", dout); end
        cycle(0, 1, '0);
        vectors++; if (dout !== 7'h43) begin miscompares++; $display("FAIL basic_pop2 got %h exp 43", dout); end
        cycle(0, 1, '0);
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL basic_empty got %b exp 1", empty); end
        vectors++; if (dout !== DW'(0)) begin miscompares++; $display("FAIL basic_dout_empty got %h exp 0", dout); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, DW'(i));
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full got %b exp 1", full); end
        vectors++; if (count !== CW'(DEPTH)) begin miscompares++; $display("FAIL fill_count got %0d exp %0d", count, DEPTH); end
        cycle(1, 0, 7'h7F);
        vectors++; if (count !== CW'(DEPTH) || dout !== DW'(0)) begin
            miscompares++; $display("FAIL overflow_ignored count=%0d head=%h exp %0d/0", count, dout, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (dout !== DW'(i)) begin miscompares++; $display("FAIL drain_order got %h exp %h", dout, DW'(i)); end
            cycle(0, 1, '0);
        end
        vectors++; if (empty !== 1'b1 || full !== 1'b0) begin
            miscompares++; $display("FAIL drain_empty empty=%b full=%b exp 1/0", empty, full);
        end
    endtask

    task automatic test_full_rdwr();
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, DW'(i));
        cycle(1, 1, 7'h55);
        vectors++; if (count !== CW'(DEPTH) || full !== 1'b1) begin
            miscompares++; $display("FAIL full_rdwr_count count=%0d full=%b exp %0d/1", count, full, DEPTH);
        end
        vectors++; if (dout !== 7'h01) begin miscompares++; $display("FAIL full_rdwr_head got %h exp 01", dout); end
        for (int i = 1; i < DEPTH; i++) begin
            vectors++; if (dout !== DW'(i)) begin miscompares++; $display("FAIL full_rdwr_order got %h exp %h", dout, DW'(i)); end
            cycle(0, 1, '0);
        end
        vectors++; if (dout !== 7'h55) begin miscompares++; $display("FAIL full_rdwr_last got %h exp 55", dout); end
        cycle(0, 1, '0);
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL full_rdwr_empty got %b exp 1", empty); end
    endtask

    task automatic test_empty_rdwr();
        cycle(1, 1, 7'h12);
        vectors++; if (count !== CW'(1) || dout !== 7'h12) begin
            miscompares++; $display("FAIL empty_rdwr count=%0d dout=%h exp 1/12", count, dout);
        end
        cycle(0, 1, '0);
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL empty_rdwr_pop got %b exp 1", empty); end
    endtask

    task automatic test_wrap_reset();
        int pushes = 0;
        bit w, r;
        logic [DW-1:0] d;
        cycle(1, 0, DW'($urandom_range(0, 127)));
        pushes = 1;
        for (int n = 0; n < 2000 && pushes < 100; n++) begin
            w = $urandom_range(0, 1); r = $urandom_range(0, 1);
            // Keep occupancy within 1..5.
            if (mq.size() == 1 && r && !w) r = 0;
            if (mq.size() == 5 && w && !r) w = 0;
            d = DW'($urandom_range(0, 127));
            cycle(w, r, d);
            if (w) pushes++;
            vectors++; if (dout !== model_head() || count !== CW'(mq.size())) begin
                miscompares++; $display("FAIL wrap_step dout=%h count=%0d exp %h/%0d", dout, count, model_head(), mq.size());
            end
        end
        vectors++; if (pushes < 100) begin miscompares++; $display("FAIL wrap_budget pushes=%0d exp 100", pushes); end
        while (mq.size() < 4) cycle(1, 0, DW'($urandom_range(0, 127)));
        while (mq.size() > 4) cycle(0, 1, '0);
        vectors++; if (count !== CW'(4)) begin miscompares++; $display("FAIL wrap_pre_reset got %0d exp 4", count); end
        // Assert reset away from any clock edge; the effect must be immediate.
        #1 rst = 1'b0;
        #1;
        vectors++; if (count !== CW'(0) || empty !== 1'b1 || dout !== DW'(0)) begin
            miscompares++; $display("FAIL async_reset count=%0d empty=%b dout=%h exp 0/1/0", count, empty, dout);
        end
        mq.delete();
        // Requests issued while reset is held are ignored.
        wr = 1'b1; rd = 1'b1; din = 7'h2A;
        @(posedge clk); #1;
        vectors++; if (count !== CW'(0) || empty !== 1'b1) begin
            miscompares++; $display("FAIL reset_ignores_wr count=%0d empty=%b exp 0/1", count, empty);
        end
        wr = 1'b0; rd = 1'b0;
        rst = 1'b1;
        cycle(1, 0, 7'h33);
        vectors++; if (count !== CW'(1) || dout !== 7'h33) begin
            miscompares++; $display("FAIL resume count=%0d dout=%h exp 1/33", count, dout);
        end
        cycle(0, 1, '0);
    endtask

    task automatic test_random();
        int pw;
        int pr;
        int bias [5] = '{80, 20, 50, 97, 3};
        bit w, r;
        for (int ph = 0; ph < 5; ph++) begin
            pw = bias[ph];
            pr = 100 - bias[ph];
            for (int n = 0; n < 80; n++) begin
                w = ($urandom_range(0, 99) < pw);
                r = ($urandom_range(0, 99) < pr);
                cycle(w, r, DW'($urandom_range(0, 127)));
                vectors++; if (count !== CW'(mq.size()) || empty !== (mq.size() == 0) ||
                               full !== (mq.size() == DEPTH) || dout !== model_head()) begin
                    miscompares++;
                    $display("FAIL random_step count=%0d empty=%b full=%b dout=%h exp %0d/%b/%b/%h",
                             count, empty, full, dout, mq.size(), mq.size() == 0, mq.size() == DEPTH, model_head());
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
        test_reset();
        test_basic();
        test_fill();
        test_full_rdwr();
        test_empty_rdwr();
        test_wrap_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
